// File: rtl/dram_rst_pkg.sv
// rtl/dram_rst_pkg.sv - shared state encoding and widths for the DRAM reset sequencer
package dram_rst_pkg;

  // Values are visible on o_state, so the encoding is fixed
  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_HOLD  = 3'd1,
    S_CALIB = 3'd2,
    S_RUN   = 3'd3,
    S_FAIL  = 3'd4
  } state_e;

  localparam int LOST_W = 4;

endpackage

// File: rtl/dram_reset_sequencer_bit_sync.sv
// rtl/dram_reset_sequencer_bit_sync.sv - multi-flop single-bit synchronizer with async preset/clear
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstx_async,
  input  logic i_rst_val,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  // Shift the input through the chain; async reset loads every flop with the reset value
  always_ff @(posedge clk or negedge rstx_async) begin
    if (!rstx_async) begin
      r_chain <= {STAGES{i_rst_val}};
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/dram_reset_sequencer.sv
// rtl/dram_reset_sequencer.sv - DRAM sys_rst sequencer with calibration timeout and retry
module dram_reset_sequencer
  import dram_rst_pkg::*;
#(
  parameter int SYNC_STAGES          = 2,
  parameter int RST_HOLD_CYCLES      = 16,
  parameter int CALIB_TIMEOUT_CYCLES = 33333334,
  parameter int MAX_RETRIES          = 3,
  parameter int CNT_W                = $clog2(CALIB_TIMEOUT_CYCLES + 1),
  parameter int RETRY_W              = $clog2(MAX_RETRIES + 1)
) (
  input  logic               clk_166_67_mhz,
  input  logic               dram_rstx_async,
  input  logic               i_calib_complete,
  output logic               o_dram_rst,
  output logic               o_calib_done,
  output logic               o_calib_fail,
  output logic [RETRY_W-1:0] o_retry_count,
  output logic [LOST_W-1:0]  o_lost_count,
  output logic [2:0]         o_state
);

  localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(CALIB_TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  logic               w_rst_rel;
  logic               w_calib_s;

  state_e             r_state;
  state_e             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [RETRY_W-1:0] r_retry;
  logic [RETRY_W-1:0] w_retry_nxt;
  logic [LOST_W-1:0]  r_lost;
  logic [LOST_W-1:0]  w_lost_nxt;
  logic               r_dram_rst;
  logic               r_calib_done;
  logic               r_calib_fail;

  // Reset release: asserts with the board reset, deasserts after SYNC_STAGES edges
  bit_sync #(.STAGES(SYNC_STAGES)) u_rst_sync (
    .clk        (clk_166_67_mhz),
    .rstx_async (dram_rstx_async),
    .i_rst_val  (1'b0),
    .i_d        (1'b1),
    .o_q        (w_rst_rel)
  );

  // init_calib_complete comes from the UI clock domain
  bit_sync #(.STAGES(SYNC_STAGES)) u_calib_sync (
    .clk        (clk_166_67_mhz),
    .rstx_async (dram_rstx_async),
    .i_rst_val  (1'b0),
    .i_d        (i_calib_complete),
    .o_q        (w_calib_s)
  );

  // Next-state, cycle counter and status counters; counter clears on every transition
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_retry_nxt = r_retry;
    w_lost_nxt  = r_lost;
    case (r_state)
      S_RESET: begin
        w_cnt_nxt = '0;
        if (w_rst_rel) begin
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (r_cnt == HOLD_LAST) begin
          w_state_nxt = S_CALIB;
          w_cnt_nxt   = '0;
        end
      end
      S_CALIB: begin
        if (w_calib_s) begin
          // Calibration wins even on the timeout cycle
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
        end else if (r_cnt == TO_LAST) begin
          w_cnt_nxt = '0;
          if (r_retry < RETRY_MAX) begin
            w_retry_nxt = r_retry + RETRY_W'(1);
            w_state_nxt = S_HOLD;
          end else begin
            w_state_nxt = S_FAIL;
          end
        end
      end
      S_RUN: begin
        w_cnt_nxt = '0;
        if (!w_calib_s) begin
          w_state_nxt = S_HOLD;
          if (r_lost != '1) begin
            w_lost_nxt = r_lost + LOST_W'(1);
          end
        end
      end
      S_FAIL: begin
        w_cnt_nxt = '0;
      end
      default: begin
        w_state_nxt = S_RESET;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State and counters; board reset aborts immediately from any state
  always_ff @(posedge clk_166_67_mhz or negedge dram_rstx_async) begin
    if (!dram_rstx_async) begin
      r_state <= S_RESET;
      r_cnt   <= '0;
      r_retry <= '0;
      r_lost  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_retry <= w_retry_nxt;
      r_lost  <= w_lost_nxt;
    end
  end

  // Outputs decoded from next-state so they move on the same edge as the state
  always_ff @(posedge clk_166_67_mhz or negedge dram_rstx_async) begin
    if (!dram_rstx_async) begin
      r_dram_rst   <= 1'b1;
      r_calib_done <= 1'b0;
      r_calib_fail <= 1'b0;
    end else begin
      r_dram_rst   <= !((w_state_nxt == S_CALIB) || (w_state_nxt == S_RUN));
      r_calib_done <= (w_state_nxt == S_RUN);
      r_calib_fail <= (w_state_nxt == S_FAIL);
    end
  end

  assign o_dram_rst    = r_dram_rst;
  assign o_calib_done  = r_calib_done;
  assign o_calib_fail  = r_calib_fail;
  assign o_retry_count = r_retry;
  assign o_lost_count  = r_lost;
  assign o_state       = r_state;

endmodule

// File: tb/tb_dram_reset_sequencer.sv
// tb/tb_dram_reset_sequencer.sv - scoreboard bench for dram_reset_sequencer
module tb_dram_reset_sequencer;

  localparam int SYNC  = 2;
  localparam int HOLD  = 4;
  localparam int TO    = 20;
  localparam int MAXR  = 2;
  localparam int RW    = 2;

  typedef struct packed {
    logic          rst;
    logic          done;
    logic          fail;
    logic [RW-1:0] retry;
    logic [3:0]    lost;
    logic [2:0]    st;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstx = 1'b0;
  logic          calib = 1'b0;
  logic          o_dram_rst;
  logic          o_calib_done;
  logic          o_calib_fail;
  logic [RW-1:0] o_retry_count;
  logic [3:0]    o_lost_count;
  logic [2:0]    o_state;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];

  // Reference model: phase number, cycles left in the phase, sync modelled as a delay line
  int   m_phase = 0;
  int   m_left  = 0;
  int   m_retry = 0;
  int   m_lost  = 0;
  int   m_hi    = 0;
  bit   m_hist[$];

  dram_reset_sequencer #(
    .SYNC_STAGES(SYNC),
    .RST_HOLD_CYCLES(HOLD),
    .CALIB_TIMEOUT_CYCLES(TO),
    .MAX_RETRIES(MAXR)
  ) dut (
    .clk_166_67_mhz   (clk),
    .dram_rstx_async  (rstx),
    .i_calib_complete (calib),
    .o_dram_rst       (o_dram_rst),
    .o_calib_done     (o_calib_done),
    .o_calib_fail     (o_calib_fail),
    .o_retry_count    (o_retry_count),
    .o_lost_count     (o_lost_count),
    .o_state          (o_state)
  );

  always #3 clk = ~clk;

  function automatic exp_t snap();
    exp_t e;
    e.rst   = !(m_phase == 2 || m_phase == 3);
    e.done  = (m_phase == 3);
    e.fail  = (m_phase == 4);
    e.retry = RW'(m_retry);
    e.lost  = 4'(m_lost);
    e.st    = 3'(m_phase);
    return e;
  endfunction

  task automatic model_clear();
    m_phase = 0; m_left = 0; m_retry = 0; m_lost = 0; m_hi = 0;
    m_hist.delete();
    for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
  endtask

  task automatic model_edge(input bit c);
    bit cs;
    cs = m_hist[0];
    case (m_phase)
      0: if (m_hi >= SYNC) begin m_phase = 1; m_left = HOLD; end
      1: begin
        m_left--;
        if (m_left == 0) begin m_phase = 2; m_left = TO; end
      end
      2: begin
        if (cs) m_phase = 3;
        else begin
          m_left--;
          if (m_left == 0) begin
            if (m_retry < MAXR) begin m_retry++; m_phase = 1; m_left = HOLD; end
            else m_phase = 4;
          end
        end
      end
      3: if (!cs) begin
        m_phase = 1; m_left = HOLD;
        if (m_lost < 15) m_lost++;
      end
      default: ;
    endcase
    void'(m_hist.pop_front());
    m_hist.push_back(c);
    if (m_hi < SYNC) m_hi++;
  endtask

  // Expectation producer: one entry per clock edge and one per async reset assertion
  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge rstx);
      if (!rstx) model_clear();
      else model_edge(calib);
      sb_q.push_back(snap());
    end
  end

  // Monitor: pops every pending expectation shortly after each event and compares
  initial begin
    exp_t e, a;
    forever begin
      @(posedge clk or negedge rstx);
      #2;
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        a = '{o_dram_rst, o_calib_done, o_calib_fail, o_retry_count, o_lost_count, o_state};
        n_tests++;
        if (a !== e) begin
          n_fail++;
          if (n_fail <= 30)
            $display("FAIL scoreboard t=%0t got rst=%0b done=%0b fail=%0b retry=%0d lost=%0d st=%0d want rst=%0b done=%0b fail=%0b retry=%0d lost=%0d st=%0d",
                     $time, a.rst, a.done, a.fail, a.retry, a.lost, a.st,
                     e.rst, e.done, e.fail, e.retry, e.lost, e.st);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic restart(input bit c);
    rstx = 1'b0;
    calib = c;
    cyc(2);
    rstx = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(3);
    // Clean bring-up with calibration already present
    calib = 1'b1;
    rstx  = 1'b1;
    cyc(40);

    // No calibration: three pulses, then permanent failure that ignores calib
    restart(1'b0);
    cyc(100);
    calib = 1'b1;
    cyc(20);

    // Calibration arriving around the timeout cycle
    for (int off = 22; off <= 27; off++) begin
      restart(1'b0);
      cyc(off);
      calib = 1'b1;
      cyc(30);
    end

    // Loss of calibration in run, enough times to saturate the lost counter
    restart(1'b1);
    cyc(30);
    for (int i = 0; i < 17; i++) begin
      calib = 1'b0;
      cyc(1);
      calib = 1'b1;
      cyc(10 + $urandom_range(0, 4));
    end

    // Board reset mid-hold and mid-calib
    restart(1'b0);
    cyc(4);
    rstx = 1'b0;
    cyc(2);
    rstx = 1'b1;
    cyc(12);
    rstx = 1'b0;
    cyc(1);
    calib = 1'b1;
    rstx = 1'b1;
    cyc(30);

    // Short asynchronous glitches on calib between edges during hold
    restart(1'b0);
    cyc(4);
    for (int i = 0; i < 3; i++) begin
      #1 calib = 1'b1;
      #1 calib = 1'b0;
      cyc(1);
    end
    cyc(30);

    // Random calib activity with occasional board resets
    restart(1'b1);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        rstx = 1'b0;
        cyc(1 + $urandom_range(0, 2));
        rstx = 1'b1;
      end
      if ($urandom_range(0, 7) == 0) calib = ~calib;
      cyc(1);
    end

    cyc(4);
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain got %0d pending want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
